// File: rtl/cram_responder_pkg.sv
// Shared definitions for the CellularRAM responder: FSM states, BCR reset value
// and the byte-lane write mask.
package cram_responder_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      RD_WAIT,
      RD_DRIVE,
      WR,
      CFG
   } state_t;

   localparam logic [15:0] BCR_RST = 16'h9D1F;

   // Active-low byte strobes become an active-high bit mask over the 16-bit word.
   function automatic logic [15:0] lane_mask(input logic ub_n, input logic lb_n);
      return {{8{~ub_n}}, {8{~lb_n}}};
   endfunction

endpackage

// File: rtl/cram_responder_mem.sv
// Backing array for the responder: single port, byte-lane write, combinational read.
module cram_responder_mem
   import cram_responder_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic              ub_n,
   input  logic              lb_n,
   input  logic [ADDR_W-1:0] addr,
   input  logic [15:0]       wdata,
   output logic [15:0]       rdata
);

   logic [15:0] mem [0:(1<<ADDR_W)-1];
   logic [15:0] mask;

   assign mask  = lane_mask(ub_n, lb_n);
   assign rdata = mem[addr];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[addr] <= (mem[addr] & ~mask) | (wdata & mask);
      end
   end

endmodule

// File: rtl/cram_responder.sv
// CellularRAM-style responder on a shared clock. Define CRAM_RESPONDER_WAIT_EN to
// drive the active-high wait output during read latency; otherwise wt is tied low.
module cram_responder
   import cram_responder_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int RD_LAT = 3
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [5:0]  a,
   input  logic [15:0] dq_in,
   output logic [15:0] dq_out,
   output logic        dq_oe,
   input  logic        adv_n,
   input  logic        cre,
   input  logic        ce_n,
   input  logic        oe_n,
   input  logic        we_n,
   input  logic        ub_n,
   input  logic        lb_n,
   output logic        wt,
   output logic        proto_err
);

   localparam logic [3:0] LAT = 4'(RD_LAT);

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] idx_q;
   logic [15:0]       lo_q;
   logic [15:0]       bcr_q;
   logic [15:0]       rd_data;
   logic [3:0]        lat_cnt;
   logic              cre_q;
   logic              we_n_q;
   logic              cfg_rd_q;
   logic              cfg_rd_nxt;
   logic              latch;
   logic              mem_we;
   logic              bcr_ld;
   logic              lat_done;

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

   // lat_cnt holds the number of clk edges seen since the address latch.
   assign lat_done = (lat_cnt >= LAT);

   always_comb begin
      state_nxt  = state;
      latch      = 1'b0;
      mem_we     = 1'b0;
      bcr_ld     = 1'b0;
      cfg_rd_nxt = 1'b0;
      if (ce_n) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (!adv_n) begin
                  latch     = 1'b1;
                  state_nxt = ADDR;
               end
            end
            ADDR: begin
               if (cre_q)      state_nxt = CFG;
               else if (!we_n) state_nxt = WR;
               else if (!oe_n) state_nxt = lat_done ? RD_DRIVE : RD_WAIT;
            end
            RD_WAIT: begin
               if (!we_n)         state_nxt = WR;
               else if (lat_done) state_nxt = RD_DRIVE;
            end
            RD_DRIVE: begin
               if (!we_n)     state_nxt = WR;
               else if (oe_n) state_nxt = ADDR;
            end
            WR: begin
               if (we_n) begin
                  mem_we    = 1'b1;
                  state_nxt = ADDR;
               end
            end
            CFG: begin
               bcr_ld     = we_n && !we_n_q;
               cfg_rd_nxt = we_n && !oe_n;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cre_q     <= 1'b0;
         lat_cnt   <= 4'd0;
         we_n_q    <= 1'b1;
         cfg_rd_q  <= 1'b0;
         bcr_q     <= BCR_RST;
         proto_err <= 1'b0;
      end else begin
         state    <= state_nxt;
         we_n_q   <= we_n;
         cfg_rd_q <= cfg_rd_nxt;
         if (latch) begin
            cre_q   <= cre;
            lat_cnt <= 4'd1;
         end else if (state != IDLE) begin
            lat_cnt <= sat_inc(lat_cnt);
         end
         if (bcr_ld) bcr_q <= lo_q;
         if (!ce_n && ((!oe_n && !we_n) || (!adv_n && state != IDLE && state != ADDR)))
            proto_err <= 1'b1;
      end
   end

   // Latched address is plain data and is left out of reset.
   always_ff @(posedge clk) begin
      if (latch) begin
         idx_q <= ADDR_W'({a, dq_in});
         lo_q  <= dq_in;
      end
   end

   cram_responder_mem #(.ADDR_W(ADDR_W)) u_mem (
      .clk   (clk),
      .wr_en (mem_we),
      .ub_n  (ub_n),
      .lb_n  (lb_n),
      .addr  (idx_q),
      .wdata (dq_in),
      .rdata (rd_data)
   );

   always_comb begin
      dq_oe  = (state == RD_DRIVE) || cfg_rd_q;
      dq_out = '0;
      if (state == RD_DRIVE) dq_out = rd_data;
      else if (cfg_rd_q)     dq_out = bcr_q;
   end

`ifdef CRAM_RESPONDER_WAIT_EN
   logic wt_arm;

   // Armed by the latch, dropped as soon as the access leaves ADDR/RD_WAIT.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                       wt_arm <= 1'b0;
      else if (latch)                                     wt_arm <= 1'b1;
      else if (state_nxt != ADDR && state_nxt != RD_WAIT) wt_arm <= 1'b0;
   end

   assign wt = wt_arm;
`else
   assign wt = 1'b0;
`endif

endmodule

// File: tb/tb_cram_responder.sv
// Randomized scoreboard bench for cram_responder with a word-level reference model.
module tb_cram_responder;

   localparam int RD_LAT = 3;
`ifdef CRAM_RESPONDER_WAIT_EN
   localparam int WT_EXP = RD_LAT;
`else
   localparam int WT_EXP = 0;
`endif

   logic        clk;
   logic        reset_n;
   logic [5:0]  a;
   logic [15:0] dq_in;
   logic [15:0] dq_out;
   logic        dq_oe;
   logic        adv_n, cre, ce_n, oe_n, we_n, ub_n, lb_n;
   logic        wt;
   logic        proto_err;

   cram_responder #(.ADDR_W(10), .RD_LAT(RD_LAT)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .a         (a),
      .dq_in     (dq_in),
      .dq_out    (dq_out),
      .dq_oe     (dq_oe),
      .adv_n     (adv_n),
      .cre       (cre),
      .ce_n      (ce_n),
      .oe_n      (oe_n),
      .we_n      (we_n),
      .ub_n      (ub_n),
      .lb_n      (lb_n),
      .wt        (wt),
      .proto_err (proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      logic [15:0] data;
      int          lat_cyc;
      bit          is_cfg;
   } exp_t;
   exp_t exp_q[$];

   // Reference model: word array indexed modulo the array depth, plus the BCR.
   logic [15:0] mdl   [1024];
   bit          known [1024];
   logic [15:0] bcr_m = 16'h9D1F;
   logic [21:0] written[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, req, $time);
   endtask

   // Monitor: pops an expectation whenever the responder starts driving dq.
   logic oe_prev = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (!dq_oe) check("dq_out_zero_when_idle", 32'(dq_out), 32'h0);
      if (dq_oe && !oe_prev) begin
         if (exp_q.size() == 0) begin
            check("unexpected_dq_oe", 32'(dq_oe), 32'h0);
         end else begin
            e = exp_q.pop_front();
            check(e.is_cfg ? "cfg_read_data" : "read_data", 32'(dq_out), 32'(e.data));
            if (!e.is_cfg) check("read_latency", 32'(cyc - e.lat_cyc), 32'(RD_LAT));
         end
      end
      oe_prev = dq_oe;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ce_n = 1'b1; adv_n = 1'b1; cre = 1'b0; oe_n = 1'b1; we_n = 1'b1;
      ub_n = 1'b1; lb_n = 1'b1; a = '0; dq_in = '0;
   endtask

   task automatic deselect();
      ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1; ub_n = 1'b1; lb_n = 1'b1;
      tick();
   endtask

   task automatic latch(input logic [21:0] ad, input logic c);
      ce_n = 1'b0; adv_n = 1'b0; cre = c; a = ad[21:16]; dq_in = ad[15:0];
      we_n = 1'b1; oe_n = 1'b1;
      tick();
      adv_n = 1'b1; cre = 1'b0;
   endtask

   task automatic model_write(input logic [21:0] ad, input logic [15:0] d,
                              input logic ub, input logic lb);
      int i;
      i = int'(ad) % 1024;
      if (!lb) mdl[i][7:0]  = d[7:0];
      if (!ub) mdl[i][15:8] = d[15:8];
      if (!ub && !lb) known[i] = 1'b1;
   endtask

   task automatic do_write(input logic [21:0] ad, input logic [15:0] d,
                           input logic ub, input logic lb);
      latch(ad, 1'b0);
      we_n = 1'b0; dq_in = d; ub_n = ub; lb_n = lb;
      tick();
      we_n = 1'b1;
      tick();
      deselect();
      model_write(ad, d, ub, lb);
      written.push_back(ad);
   endtask

   task automatic do_read(input logic [21:0] ad, input logic [15:0] expv);
      int wt_cnt;
      int n;
      latch(ad, 1'b0);
      exp_q.push_back('{expv, cyc, 1'b0});
      wt_cnt = int'(wt);
      oe_n = 1'b0;
      n = 0;
      while (!dq_oe && n < 20) begin
         tick();
         wt_cnt += int'(wt);
         n++;
      end
      check("read_dq_oe_seen", 32'(dq_oe), 32'h1);
      oe_n = 1'b1;
      tick();
      wt_cnt += int'(wt);
      check("dq_oe_drop_after_oe_n", 32'(dq_oe), 32'h0);
      deselect();
      wt_cnt += int'(wt);
      check("wt_cycles_per_read", 32'(wt_cnt), 32'(WT_EXP));
   endtask

   task automatic cfg_write(input logic [15:0] v);
      latch({6'h00, v}, 1'b1);
      we_n = 1'b0;
      tick();
      we_n = 1'b1;
      tick();
      deselect();
      bcr_m = v;
   endtask

   task automatic cfg_read();
      int n;
      latch(22'($urandom), 1'b1);
      exp_q.push_back('{bcr_m, cyc, 1'b1});
      oe_n = 1'b0;
      n = 0;
      while (!dq_oe && n < 20) begin
         tick();
         n++;
      end
      check("cfg_dq_oe_seen", 32'(dq_oe), 32'h1);
      oe_n = 1'b1;
      tick();
      deselect();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      logic [21:0] ad;
      logic [15:0] d;
      logic        ub, lb;
      int          k;

      idle_inputs();
      reset_n = 1'b0;
      #3;
      check("reset_dq_oe", 32'(dq_oe), 32'h0);
      check("reset_dq_out", 32'(dq_out), 32'h0);
      check("reset_wt", 32'(wt), 32'h0);
      check("reset_proto_err", 32'(proto_err), 32'h0);
      tick();
      tick();
      reset_n = 1'b1;
      tick();

      do_write(22'h00012, 16'hA5C3, 1'b0, 1'b0);
      do_read(22'h00012, 16'hA5C3);

      do_write(22'h00020, 16'hFFFF, 1'b0, 1'b0);
      do_write(22'h00020, 16'h1234, 1'b1, 1'b0);
      do_read(22'h00020, 16'hFF34);

      do_write(22'h00400, 16'h5555, 1'b0, 1'b0);
      do_read(22'h00000, 16'h5555);

      do_write(22'h00030, 16'h0F0F, 1'b0, 1'b0);
      do_write(22'h00030, 16'hBEEF, 1'b1, 1'b1);
      do_read(22'h00030, 16'h0F0F);

      cfg_read();
      cfg_write(16'h8110);
      cfg_read();

      for (int i = 0; i < 25; i++) begin
         ad = 22'($urandom);
         d  = 16'($urandom);
         ub = 1'($urandom);
         lb = 1'($urandom);
         if (!known[int'(ad) % 1024]) begin
            ub = 1'b0;
            lb = 1'b0;
         end
         do_write(ad, d, ub, lb);
         ad = written[$urandom_range(0, written.size() - 1)];
         do_read(ad, mdl[int'(ad) % 1024]);
      end

      // Deselect while the read is still waiting out its latency.
      latch(22'h00012, 1'b0);
      oe_n = 1'b0;
      tick();
      ce_n = 1'b1; oe_n = 1'b1;
      tick();
      check("abort_rd_dq_oe", 32'(dq_oe), 32'h0);
      check("abort_rd_wt", 32'(wt), 32'h0);

      // Deselect with we_n rising: the write must be dropped.
      latch(22'h00012, 1'b0);
      we_n = 1'b0; dq_in = 16'h0000; ub_n = 1'b0; lb_n = 1'b0;
      tick();
      ce_n = 1'b1; we_n = 1'b1;
      tick();
      check("abort_wr_dq_oe", 32'(dq_oe), 32'h0);
      check("abort_wr_wt", 32'(wt), 32'h0);
      deselect();
      do_read(22'h00012, 16'hA5C3);

      check("proto_err_clean", 32'(proto_err), 32'h0);
      latch(22'h00044, 1'b0);
      we_n = 1'b0; oe_n = 1'b0; dq_in = 16'h6C6C; ub_n = 1'b0; lb_n = 1'b0;
      tick();
      oe_n = 1'b1; we_n = 1'b1;
      tick();
      deselect();
      model_write(22'h00044, 16'h6C6C, 1'b0, 1'b0);
      check("proto_err_set", 32'(proto_err), 32'h1);
      do_read(22'h00044, 16'h6C6C);
      check("proto_err_sticky", 32'(proto_err), 32'h1);

      // Asynchronous reset while a CFG read is driving dq.
      latch(22'h00000, 1'b1);
      exp_q.push_back('{bcr_m, cyc, 1'b1});
      oe_n = 1'b0;
      tick();
      tick();
      @(negedge clk);
      #1;
      check("cfg_drive_before_reset", 32'(dq_oe), 32'h1);
      reset_n = 1'b0;
      #1;
      check("async_reset_dq_oe", 32'(dq_oe), 32'h0);
      check("async_reset_dq_out", 32'(dq_out), 32'h0);
      check("async_reset_wt", 32'(wt), 32'h0);
      check("async_reset_proto_err", 32'(proto_err), 32'h0);
      idle_inputs();
      tick();
      reset_n = 1'b1;
      tick();
      bcr_m = 16'h9D1F;
      cfg_read();
      do_read(22'h00044, 16'h6C6C);

      k = 0;
      while (exp_q.size() != 0 && k < 10) begin
         tick();
         k++;
      end
      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
